// File: rtl/bram_sp_pkg.sv
// ============================================================================
// Module : bram_sp_pkg
// Brief  : Shared types and default widths for the single-port BRAM stream
//          controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_sp_pkg;

    localparam int unsigned c_DEF_ADDR_W = 10;
    localparam int unsigned c_DEF_DATA_W = 16;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/bram_rd_fifo2.sv
// ============================================================================
// Module : bram_rd_fifo2
// Brief  : Two-entry registered FIFO holding returned read data.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rd_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_sp_stream_ctrl.sv
// ============================================================================
// Module : bram_sp_stream_ctrl
// Brief  : Arbitrates write and read-request streams onto one write-first
//          BRAM port, returns read data with backpressure, clears the RAM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sp_stream_ctrl
    import bram_sp_pkg::*;
#(
    parameter int               ADDR_W    = c_DEF_ADDR_W,
    parameter int               DATA_W    = c_DEF_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              s_wr_valid,
    output logic              s_wr_ready,
    input  logic [ADDR_W-1:0] s_wr_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    input  logic              s_rd_valid,
    output logic              s_rd_ready,
    input  logic [ADDR_W-1:0] s_rd_addr,
    output logic              m_rd_valid,
    input  logic              m_rd_ready,
    output logic [DATA_W-1:0] m_rd_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    grant_t            r_last_grant;
    logic              r_rd_pend;

    logic              w_run;
    logic              w_rd_eligible;
    logic              w_wr_ready;
    logic              w_rd_ready;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;

    assign w_run = (r_state == ST_RUN);

    // Outstanding slots: FIFO entries plus the read whose data is still in dout.
    assign w_rd_eligible = !w_fifo_full &&
                           (({1'b0, w_fifo_count} + {2'b00, r_rd_pend}) < 3'd2);

    // Readies look only at the other stream's valid, never their own.
    assign w_rd_ready = w_run && w_rd_eligible &&
                        !(s_wr_valid && (r_last_grant == GNT_RD));
    assign w_wr_ready = w_run &&
                        !(s_rd_valid && w_rd_eligible && (r_last_grant == GNT_WR));
    assign w_wr_fire  = s_wr_valid && w_wr_ready;
    assign w_rd_fire  = s_rd_valid && w_rd_ready;

    assign s_wr_ready = w_wr_ready;
    assign s_rd_ready = w_rd_ready;
    assign m_rd_valid = !w_fifo_empty;
    assign w_pop      = !w_fifo_empty && m_rd_ready;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = s_rd_addr;
        ram_di      = s_wr_data;
        case (r_state)
            ST_CLEAR: begin
                busy     = 1'b1;
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_clr_addr;
                ram_di   = CLEAR_VAL;
                if (r_clr_addr == c_LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ram_en   = w_wr_fire || w_rd_fire;
                ram_we   = w_wr_fire;
                ram_addr = w_wr_fire ? s_wr_addr : s_rd_addr;
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_clr_addr   <= '0;
            r_last_grant <= GNT_RD;
            r_rd_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_rd_fire;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + c_ADDR_ONE;
            end else if (clr_req) begin
                r_clr_addr <= '0;
            end
            if (w_wr_fire) begin
                r_last_grant <= GNT_WR;
            end else if (w_rd_fire) begin
                r_last_grant <= GNT_RD;
            end
        end
    end

    // dout must be captured the cycle after issue; a following write replaces it.
    bram_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_rd_pend),
        .push_data (ram_dout),
        .pop       (w_pop),
        .head      (m_rd_data),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_sp_stream_ctrl.sv
// ============================================================================
// Module : tb_bram_sp_stream_ctrl
// Brief  : Self-checking bench for bram_sp_stream_ctrl with a write-first
//          BRAM model and a shadow-memory scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_sp_stream_ctrl;

    localparam int          AW = 4;
    localparam int          DW = 16;
    localparam int          DEPTH = 16;
    localparam logic [15:0] CV = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_req;
    logic          busy;
    logic          s_wr_valid, s_wr_ready;
    logic [AW-1:0] s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic          s_rd_valid, s_rd_ready;
    logic [AW-1:0] s_rd_addr;
    logic          m_rd_valid, m_rd_ready;
    logic [DW-1:0] m_rd_data;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    bram_sp_stream_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLEAR_VAL (CV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .busy       (busy),
        .s_wr_valid (s_wr_valid),
        .s_wr_ready (s_wr_ready),
        .s_wr_addr  (s_wr_addr),
        .s_wr_data  (s_wr_data),
        .s_rd_valid (s_rd_valid),
        .s_rd_ready (s_rd_ready),
        .s_rd_addr  (s_rd_addr),
        .m_rd_valid (m_rd_valid),
        .m_rd_ready (m_rd_ready),
        .m_rd_data  (m_rd_data),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_dout   (ram_dout)
    );

    // Write-first single-port BRAM, 1-cycle read latency.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_di;
                ram_dout          <= ram_di;
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_ret    = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
    endfunction

    // Reference model: what the RAM should hold, and the read data owed in order.
    logic [DW-1:0] shadow [DEPTH];
    logic [DW-1:0] exp_q [$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) shadow[i] = CV;
            chk("rst_m_valid", 32'(m_rd_valid), 32'd0);
        end else begin
            if (busy) begin
                for (int i = 0; i < DEPTH; i++) shadow[i] = CV;
                chk("busy_readies", 32'({s_wr_ready, s_rd_ready}), 32'd0);
            end
            if (m_rd_valid && m_rd_ready) begin
                n_ret++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_spurious: got %0h expected no data", m_rd_data);
                end else begin
                    chk("sb_data", 32'(m_rd_data), 32'(exp_q.pop_front()));
                end
            end
            if (s_wr_valid && s_wr_ready && s_rd_valid && s_rd_ready)
                chk("one_op_per_cycle", 32'd2, 32'd1);
            if (s_wr_valid && s_wr_ready) shadow[s_wr_addr] = s_wr_data;
            if (s_rd_valid && s_rd_ready) exp_q.push_back(shadow[s_rd_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        s_wr_valid = 1'b1; s_wr_addr = a; s_wr_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_wr_ready) begin ok = 1; break; end
        end
        tick();
        s_wr_valid = 1'b0;
        if (!ok) fail_now("wr_accept");
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit ok = 0;
        s_rd_valid = 1'b1; s_rd_addr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_rd_ready) begin ok = 1; break; end
        end
        tick();
        s_rd_valid = 1'b0;
        if (!ok) fail_now("rd_accept");
    endtask

    task automatic wait_data(input string name, input logic [DW-1:0] exp);
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_rd_valid) begin
                chk(name, 32'(m_rd_data), 32'(exp));
                ok = 1;
                break;
            end
        end
        tick();
        if (!ok) fail_now(name);
    endtask

    task automatic drain();
        bit ok = 0;
        s_wr_valid = 1'b0; s_rd_valid = 1'b0; m_rd_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !m_rd_valid) begin ok = 1; break; end
            tick();
        end
        if (!ok) fail_now("drain");
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        chk(name, 32'(n), 32'(DEPTH));
        tick();
    endtask

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
    } vec_t;

    vec_t tbl [12];
    int   g [12];
    int   base, accepted;

    initial begin
        tbl[0]  = '{1'b1, 4'd3,  16'h1234};
        tbl[1]  = '{1'b0, 4'd3,  16'h1234};
        tbl[2]  = '{1'b0, 4'd5,  16'hA5A5};
        tbl[3]  = '{1'b1, 4'd5,  16'h5555};
        tbl[4]  = '{1'b1, 4'd7,  16'h0F0F};
        tbl[5]  = '{1'b0, 4'd7,  16'h0F0F};
        tbl[6]  = '{1'b0, 4'd5,  16'h5555};
        tbl[7]  = '{1'b1, 4'd3,  16'hFFFF};
        tbl[8]  = '{1'b0, 4'd3,  16'hFFFF};
        tbl[9]  = '{1'b0, 4'd0,  16'hA5A5};
        tbl[10] = '{1'b1, 4'd15, 16'h8001};
        tbl[11] = '{1'b0, 4'd15, 16'h8001};

        rst = 1'b1; clr_req = 1'b0;
        s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_rd_valid = 1'b0; s_rd_addr = '0; m_rd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rd_ready", 32'(s_rd_ready), 32'd0);
        rst = 1'b0;
        count_busy("init_clear_cycles");
        chk("run_wr_ready", 32'(s_wr_ready), 32'd1);

        // Every word reads back as the clear value.
        base = n_ret;
        for (int a = 0; a < DEPTH; a++) do_read(AW'(a));
        drain();
        chk("init_sweep_count", 32'(n_ret - base), 32'(DEPTH));

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data);
            else begin
                do_read(tbl[i].addr);
                wait_data("tbl_read", tbl[i].data);
            end
        end
        drain();

        // Write then read the same address back to back; data two cycles after the read.
        s_wr_valid = 1'b1; s_wr_addr = 4'd3; s_wr_data = 16'h1234;
        @(negedge clk); chk("lat_wr_ready", 32'(s_wr_ready), 32'd1);
        tick();
        s_wr_valid = 1'b0; s_rd_valid = 1'b1; s_rd_addr = 4'd3;
        @(negedge clk); chk("lat_rd_ready", 32'(s_rd_ready), 32'd1);
        tick();
        s_rd_valid = 1'b0;
        @(negedge clk); chk("lat_not_early", 32'(m_rd_valid), 32'd0);
        @(negedge clk); chk("lat_valid", 32'(m_rd_valid), 32'd1);
        chk("lat_data", 32'(m_rd_data), 32'h1234);
        tick();
        drain();

        // Read then write in the next cycle: the read returns the old word.
        s_rd_valid = 1'b1; s_rd_addr = 4'd5;
        @(negedge clk); chk("rw_rd_ready", 32'(s_rd_ready), 32'd1);
        tick();
        s_rd_valid = 1'b0; s_wr_valid = 1'b1; s_wr_addr = 4'd7; s_wr_data = 16'hBEEF;
        @(negedge clk); chk("rw_wr_ready", 32'(s_wr_ready), 32'd1);
        tick();
        s_wr_valid = 1'b0;
        wait_data("rw_old_data", 16'h5555);
        do_read(4'd7);
        wait_data("rw_new_data", 16'hBEEF);
        drain();

        // Both streams valid every cycle: grants must alternate.
        s_wr_valid = 1'b1; s_rd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_wr_addr = AW'($urandom); s_wr_data = DW'($urandom); s_rd_addr = AW'($urandom);
            @(negedge clk);
            g[i] = (s_wr_valid && s_wr_ready) ? 0 : ((s_rd_valid && s_rd_ready) ? 1 : 2);
            tick();
        end
        s_wr_valid = 1'b0; s_rd_valid = 1'b0;
        chk("alt_first_fire", 32'(g[0] < 2), 32'd1);
        for (int i = 1; i < 12; i++) chk("alt_grant", 32'(g[i]), 32'(g[i-1] == 0 ? 1 : 0));
        drain();

        // Stalled consumer: only two reads may be outstanding.
        m_rd_ready = 1'b0; s_rd_valid = 1'b1; accepted = 0;
        for (int i = 0; i < 5; i++) begin
            s_rd_addr = AW'($urandom);
            @(negedge clk);
            if (s_rd_ready) accepted++;
            tick();
        end
        @(negedge clk);
        chk("bp_rd_ready_low", 32'(s_rd_ready), 32'd0);
        chk("bp_m_valid", 32'(m_rd_valid), 32'd1);
        tick();
        s_rd_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd2);
        base = n_ret;
        drain();
        chk("bp_returned", 32'(n_ret - base), 32'd2);

        for (int i = 0; i < 400; i++) begin
            s_wr_valid = 1'($urandom); s_wr_addr = AW'($urandom); s_wr_data = DW'($urandom);
            s_rd_valid = 1'($urandom); s_rd_addr = AW'($urandom);
            m_rd_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        // clr_req with a read accepted in the same cycle.
        base = n_ret;
        s_rd_valid = 1'b1; s_rd_addr = AW'($urandom); clr_req = 1'b1;
        @(negedge clk); chk("clr_rd_ready", 32'(s_rd_ready), 32'd1);
        tick();
        clr_req = 1'b0; s_rd_valid = 1'b0; s_wr_valid = 1'b1;
        count_busy("clr_sweep_cycles");
        s_wr_valid = 1'b0;
        drain();
        chk("clr_pending_delivered", 32'(n_ret - base), 32'd1);

        // Reset during a clear with data parked in the FIFO.
        m_rd_ready = 1'b0;
        do_read(4'd1);
        do_read(4'd2);
        repeat (3) tick();
        chk("pre_rst_fifo_full", 32'(m_rd_valid), 32'd1);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        repeat (4) tick();
        chk("mid_clear_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("post_rst_fifo_empty", 32'(m_rd_valid), 32'd0);
        count_busy("rst_clear_cycles");
        m_rd_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            do_read(AW'(a));
            wait_data("final_clear_val", CV);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
